// File: rtl/rot_pkg.sv
// Shared definitions for the T_Rot rotation blocks: state encoding,
// direction constants and step count width.
package rot_pkg;

  localparam int unsigned CW = 5;

  localparam logic DIR_CCW = 1'b0;
  localparam logic DIR_CW  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } rot_state_e;

endpackage

// File: rtl/rot_prescaler.sv
// Step-tick prescaler: counts clk cycles while enabled and flags the cycle
// in which the count sits at PRESCALE-1 (the wrap cycle).
module rot_prescaler #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PW       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count;

  assign tick_c = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick_c ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/rot_step_counter.sv
// Timed in-place rotation sequencer: drives the turn motors, counts prescaled
// step ticks into cnt_out and ends the turn on the external comparator's E/G.
module rot_step_counter
  import rot_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir_in,
  input  logic [CW-1:0] target_in,
  input  logic          abort,
  input  logic          cmp_e,
  input  logic          cmp_g,
  output logic [CW-1:0] cnt_out,
  output logic [CW-1:0] target_out,
  output logic          motor_l,
  output logic          motor_r,
  output logic          busy,
  output logic          done,
  output logic          fault
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  rot_state_e    state, state_nxt;
  logic          dir, dir_nxt;
  logic [CW-1:0] cnt_nxt, target_nxt;
  logic          motor_l_nxt, motor_r_nxt, busy_nxt, done_nxt, fault_nxt;
  logic          pre_en, pre_clr, tick_c;

  // Prescaler only runs in RUN and restarts from zero on every accepted start.
  assign pre_en  = (state == RUN);
  assign pre_clr = (state == IDLE) && start;

  rot_prescaler #(
    .PRESCALE(PRESCALE),
    .PW      (PW)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick_c(tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= DIR_CCW;
      cnt_out    <= '0;
      target_out <= '0;
      motor_l    <= 1'b0;
      motor_r    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      cnt_out    <= cnt_nxt;
      target_out <= target_nxt;
      motor_l    <= motor_l_nxt;
      motor_r    <= motor_r_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      fault      <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    cnt_nxt     = cnt_out;
    target_nxt  = target_out;
    motor_l_nxt = motor_l;
    motor_r_nxt = motor_r;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    fault_nxt   = fault;

    case (state)
      IDLE: begin
        if (start) begin
          target_nxt = target_in;
          dir_nxt    = dir_in;
          cnt_nxt    = '0;
          fault_nxt  = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = LOAD;
        end
      end

      // One settle cycle so the comparator sees the freshly latched A/B.
      LOAD: begin
        if (cmp_e) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          motor_l_nxt = (dir == DIR_CCW);
          motor_r_nxt = (dir == DIR_CW);
          state_nxt   = RUN;
        end
      end

      RUN: begin
        if (abort || cmp_g || cmp_e) begin
          motor_l_nxt = 1'b0;
          motor_r_nxt = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
          if (abort) begin
            fault_nxt = fault;
          end else if (cmp_g) begin
            fault_nxt = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end else if (tick_c) begin
          // Saturated count with no match can never complete: give up as a fault.
          if (cnt_out == CNT_MAX) begin
            motor_l_nxt = 1'b0;
            motor_r_nxt = 1'b0;
            busy_nxt    = 1'b0;
            fault_nxt   = 1'b1;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt_out + CW'(1);
          end
        end
      end

      default: begin
        motor_l_nxt = 1'b0;
        motor_r_nxt = 1'b0;
        busy_nxt    = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rot_step_counter.sv
// Randomized scoreboard bench for rot_step_counter with the 5-bit comparator
// modelled alongside; turn outcomes come from an arithmetic reference model.
module tb_rot_step_counter;

  localparam int unsigned PRESCALE = 4;
  localparam int K_NORMAL = 0;
  localparam int K_ABORT  = 1;
  localparam int K_OVER   = 2;
  localparam int K_RESET  = 3;
  localparam int K_SAT    = 4;

  logic       clk = 1'b0;
  logic       rst, start, dir_in, abort, cmp_e, cmp_g;
  logic [4:0] target_in, cnt_out, target_out;
  logic       motor_l, motor_r, busy, done, fault;
  logic       force_g, kill;

  always #5 clk = ~clk;

  // Parent-level comparator; force_g injects an overshoot, kill hides both results.
  assign cmp_e = !kill && (cnt_out == target_out);
  assign cmp_g = !kill && (force_g || (cnt_out > target_out));

  rot_step_counter #(
    .PRESCALE(PRESCALE),
    .PW      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir_in    (dir_in),
    .target_in (target_in),
    .abort     (abort),
    .cmp_e     (cmp_e),
    .cmp_g     (cmp_g),
    .cnt_out   (cnt_out),
    .target_out(target_out),
    .motor_l   (motor_l),
    .motor_r   (motor_r),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  typedef struct {
    int tgt;
    int dir;
    int exp_done;
    int exp_fault;
    int exp_cnt;
    int exp_tgt;
    int exp_len;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_seen   = 0;
  int   done_exp    = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Outcome of one turn; k is the edge index (start edge = 0) of the abort,
  // forced overshoot or reset. Turn length counts busy-high cycles.
  function automatic exp_t model(input int t, input int d, input int kind, input int k);
    exp_t m;
    m.tgt = t; m.dir = d; m.exp_done = 0; m.exp_fault = 0;
    m.exp_tgt = t; m.exp_cnt = 0; m.exp_len = k;
    case (kind)
      K_NORMAL: begin
        m.exp_done = 1;
        m.exp_cnt  = t;
        m.exp_len  = (t == 0) ? 1 : PRESCALE * t + 2;
      end
      K_ABORT: m.exp_cnt = (k - 2) / PRESCALE;
      K_OVER: begin
        m.exp_fault = 1;
        m.exp_cnt   = (k - 2) / PRESCALE;
      end
      K_RESET: m.exp_tgt = 0;
      default: begin
        m.exp_fault = 1;
        m.exp_cnt   = 31;
        m.exp_len   = PRESCALE * 32 + 1;
      end
    endcase
    return m;
  endfunction

  // Monitor: follows each busy window and scores it against the queue head.
  int   idx = 0, bad_m = 0, bad_c = 0;
  bit   prev_busy = 1'b0, in_turn = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (busy === 1'b1 && !prev_busy) begin
      if (sbq.size() == 0) begin
        check("unexpected_turn", 1, 0);
      end else begin
        cur = sbq[0];
        idx = 0; bad_m = 0; bad_c = 0; in_turn = 1'b1;
        check("start_fault_clear", int'(fault), 0);
        check("start_cnt", int'(cnt_out), 0);
        check("start_target", int'(target_out), cur.tgt);
      end
    end
    if (busy === 1'b1 && in_turn) begin
      if (idx == 0) begin
        if (motor_l || motor_r) bad_m++;
      end else begin
        if (motor_r != cur.dir[0] || motor_l != !cur.dir[0]) bad_m++;
        if (int'(cnt_out) != (((idx - 1) / PRESCALE > 31) ? 31 : (idx - 1) / PRESCALE)) bad_c++;
      end
      idx++;
    end
    if (busy === 1'b0 && prev_busy && in_turn) begin
      cur = sbq.pop_front();
      in_turn = 1'b0;
      check("end_done", int'(done), cur.exp_done);
      check("end_fault", int'(fault), cur.exp_fault);
      check("end_cnt", int'(cnt_out), cur.exp_cnt);
      check("end_target", int'(target_out), cur.exp_tgt);
      check("end_motors_off", int'(motor_l | motor_r), 0);
      check("turn_len", idx, cur.exp_len);
      check("motor_dir_bad", bad_m, 0);
      check("cnt_step_bad", bad_c, 0);
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      abort     = 1'($urandom);
      target_in = 5'($urandom);
      dir_in    = 1'($urandom);
    end
    abort = 1'b0;
  endtask

  // Issue one turn starting at the current negedge; kx is the edge of an
  // extra (ignored) start, both requests abort together with the start.
  task automatic run_turn(input int t, input int d, input int kind, input int k,
                          input int kx, input int both);
    exp_t m;
    int   e;
    bit   ended;
    m = model(t, d, kind, k);
    sbq.push_back(m);
    if (m.exp_done != 0) done_exp++;
    start = 1'b1; target_in = 5'(t); dir_in = 1'(d); abort = 1'(both);
    kill = (kind == K_SAT);
    e = 0; ended = 1'b0;
    for (int guard = 0; guard < 400 && !ended; guard++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; force_g = 1'b0; rst = 1'b0;
      target_in = 5'($urandom); dir_in = 1'($urandom);
      if (!busy) begin
        ended = 1'b1;
      end else begin
        e++;
        abort   = (kind == K_ABORT) && (e == k);
        force_g = (kind == K_OVER)  && (e == k);
        rst     = (kind == K_RESET) && (e == k);
        if (kx != 0 && e == kx) begin
          start = 1'b1; target_in = 5'd7;
        end
      end
    end
    kill = 1'b0;
    if (!ended) check("turn_timeout", 0, 1);
  endtask

  initial begin
    int   t, kind, k, kx;
    exp_t m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; force_g = 1'b0; kill = 1'b0;
    dir_in = 1'b0; target_in = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_cnt", int'(cnt_out), 0);
    check("rst_target", int'(target_out), 0);
    check("rst_motors", int'(motor_l | motor_r), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    rst = 1'b0;
    @(negedge clk);

    run_turn(3, 1, K_NORMAL, 0, 6, 0);
    idle(2);
    run_turn(0, 0, K_NORMAL, 0, 0, 1);
    idle(1);
    run_turn(10, 0, K_ABORT, 19, 0, 0);
    idle(3);
    check("abort_hold_cnt", int'(cnt_out), 4);
    check("abort_hold_target", int'(target_out), 10);
    run_turn(10, 1, K_OVER, 10, 0, 0);
    idle(2);
    check("fault_sticky", int'(fault), 1);
    run_turn(5, 0, K_NORMAL, 0, 1, 0);
    run_turn(10, 1, K_RESET, 24, 0, 0);
    run_turn(2, 1, K_NORMAL, 0, 0, 0);
    idle(1);
    run_turn(31, 0, K_NORMAL, 0, 0, 0);
    idle(1);
    run_turn(20, 1, K_SAT, 0, 0, 0);
    idle(2);

    for (int n = 0; n < 30; n++) begin
      t    = int'($urandom_range(0, 31));
      kind = (t == 0) ? K_NORMAL : int'($urandom_range(0, 3));
      k    = 0;
      if (kind != K_NORMAL)
        k = PRESCALE * int'($urandom_range(0, t - 1)) + 2 + int'($urandom_range(0, 3));
      m  = model(t, 0, kind, k);
      kx = ($urandom_range(0, 2) == 0 && m.exp_len > 1) ? int'($urandom_range(1, m.exp_len - 1)) : 0;
      run_turn(t, int'($urandom_range(0, 1)), kind, k, kx, int'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end

    idle(5);
    check("done_pulses", done_seen, done_exp);
    check("queue_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
